// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encodings,
// hold/flush bit positions and the common zero constants.
package pipe_ctrl_pkg;
  localparam int RegAddrBus = 5;
  localparam logic [31:0]           ZeroWord = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] ZeroReg  = '0;

  localparam int Hold_Pc   = 0;
  localparam int Hold_IfId = 1;
  localparam int Hold_IdEx = 2;

  localparam int Flush_IfId = 0;
  localparam int Flush_IdEx = 1;

  typedef enum logic [1:0] {
    PIPE_RUN    = 2'd0,
    PIPE_BUBBLE = 2'd1,
    PIPE_WAIT   = 2'd2,
    PIPE_REDIR  = 2'd3
  } pipe_state_e;

  typedef struct packed {
    logic [2:0]  hold;
    logic [1:0]  flush;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        irq_ack;
    logic        timeout;
  } pipe_ctl_t;
endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use compare: the load in EX writes a register that ID is reading now.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic                  ld_valid,
  input  logic [RegAddrBus-1:0] ld_rd,
  input  logic [RegAddrBus-1:0] rs1,
  input  logic [RegAddrBus-1:0] rs2,
  output logic                  hazard
);
  // x0 is hardwired to zero, so a load into it never creates a dependency.
  assign hazard = ld_valid && (ld_rd != ZeroReg) && ((ld_rd == rs1) || (ld_rd == rs2));
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates redirects, holds and load-use
// bubbles for the 3-stage core and drives per-stage hold/flush and PC load.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_flag_i,
  input  logic [31:0]           jump_addr_i,
  input  logic                  irq_req_i,
  input  logic [31:0]           irq_addr_i,
  input  logic                  ex_busy_i,
  input  logic                  bus_wait_i,
  input  logic                  ld_valid_i,
  input  logic [RegAddrBus-1:0] ld_rd_i,
  input  logic [RegAddrBus-1:0] id_rs1_i,
  input  logic [RegAddrBus-1:0] id_rs2_i,
  output logic [2:0]            hold_o,
  output logic [1:0]            flush_o,
  output logic                  pc_load_o,
  output logic [31:0]           pc_target_o,
  output logic                  irq_ack_o,
  output logic                  timeout_o,
  output logic [31:0]           stall_cnt_o
);
  localparam int WAIT_W = 8;

  pipe_state_e       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  pipe_ctl_t         ctl;
  logic              hazard, hold_req;
  logic              do_jump, do_irq, do_hold, do_lu;

  hazard_detect u_hazard (
    .ld_valid (ld_valid_i),
    .ld_rd    (ld_rd_i),
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .hazard   (hazard)
  );

  always_comb begin
    hold_req = ex_busy_i | bus_wait_i;
    do_jump  = jump_flag_i;
    do_irq   = !do_jump && irq_req_i && (state == PIPE_RUN);
    do_hold  = !do_jump && !do_irq && hold_req;
    do_lu    = !do_jump && !do_irq && !hold_req && (state == PIPE_RUN) && hazard;
  end

  // Mealy decode; everything is forced to zero while reset is asserted.
  always_comb begin
    ctl           = '0;
    ctl.pc_target = ZeroWord;
    state_nxt     = PIPE_RUN;
    if (!rst) begin
      if (do_jump) begin
        ctl.pc_load           = 1'b1;
        ctl.pc_target         = jump_addr_i;
        ctl.flush[Flush_IfId] = 1'b1;
        ctl.flush[Flush_IdEx] = 1'b1;
        state_nxt             = PIPE_REDIR;
      end else if (do_irq) begin
        ctl.irq_ack           = 1'b1;
        ctl.pc_load           = 1'b1;
        ctl.pc_target         = irq_addr_i;
        ctl.flush[Flush_IfId] = 1'b1;
        ctl.flush[Flush_IdEx] = 1'b1;
        state_nxt             = PIPE_REDIR;
      end else if (do_hold) begin
        ctl.hold[Hold_Pc]   = 1'b1;
        ctl.hold[Hold_IfId] = 1'b1;
        ctl.hold[Hold_IdEx] = 1'b1;
        ctl.timeout         = (wait_cnt == WAIT_W'(WAIT_MAX - 1));
        state_nxt           = PIPE_WAIT;
      end else if (do_lu) begin
        ctl.hold[Hold_Pc]     = 1'b1;
        ctl.hold[Hold_IfId]   = 1'b1;
        ctl.flush[Flush_IdEx] = 1'b1;
        state_nxt             = PIPE_BUBBLE;
      end else if (state == PIPE_REDIR) begin
        // the synchronous fetch issued before the redirect is still in flight
        ctl.flush[Flush_IfId] = 1'b1;
      end
    end
  end

  assign hold_o      = ctl.hold;
  assign flush_o     = ctl.flush;
  assign pc_load_o   = ctl.pc_load;
  assign pc_target_o = ctl.pc_target;
  assign irq_ack_o   = ctl.irq_ack;
  assign timeout_o   = ctl.timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PIPE_RUN;
      wait_cnt    <= '0;
      stall_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      // counter parks at WAIT_MAX so the timeout pulse fires only once per hold
      if (!do_hold)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_W'(WAIT_MAX))
        wait_cnt <= wait_cnt + 1'b1;
      if (ctl.hold[Hold_Pc] && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule
